// File: rtl/inst_cache_pkg.sv
// ============================================================================
// inst_cache_pkg : shared widths, reset values and refill state encodings
// Revision       : 1.0
// ============================================================================
`default_nettype none

package inst_cache_pkg;

  localparam int DataSize = 32;
  localparam logic [DataSize-1:0] DataBusReset = '0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

endpackage

`default_nettype wire

// File: rtl/icache_refill_fsm.sv
// ============================================================================
// icache_refill_fsm : miss sequencing (REQ/FILL/RESP), beat counter, mem handshake
// Revision          : 1.0
// ============================================================================
`default_nettype none

module icache_refill_fsm
  import inst_cache_pkg::*;
#(
  parameter int DATA_W = DataSize,
  parameter int WORDS  = 4
) (
  input  logic                       clk,
  input  logic                       resetIn,
  input  logic                       startIn,
  input  logic [DATA_W-1:0]          addrIn,
  input  logic                       memReqReady,
  input  logic                       memRespValid,
  output logic [1:0]                 stateOut,
  output logic [$clog2(WORDS)-1:0]   beatOut,
  output logic                       beatWeOut,
  output logic                       lastBeatOut,
  output logic [DATA_W-1:0]          reqAddrOut,
  output logic                       memReqValid,
  output logic [DATA_W-1:0]          memReqAddr
);

  localparam int OFF_W = $clog2(WORDS);

  logic [1:0]        state_q, state_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic              memReqValid_q, memReqValid_d;
  logic [DATA_W-1:0] memReqAddr_q, memReqAddr_d;
  logic [DATA_W-1:0] reqAddr_q, reqAddr_d;

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    memReqValid_d = memReqValid_q;
    memReqAddr_d  = memReqAddr_q;
    reqAddr_d     = reqAddr_q;
    case (state_q)
      ST_IDLE: begin
        if (startIn) begin
          state_d       = ST_REQ;
          reqAddr_d     = addrIn;
          memReqValid_d = 1'b1;
          memReqAddr_d  = {addrIn[DATA_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
        end
      end
      ST_REQ: begin
        if (memReqReady) begin
          memReqValid_d = 1'b0;
          beat_d        = '0;
          state_d       = ST_FILL;
        end
      end
      ST_FILL: begin
        // Counter wraps back to zero on the final beat.
        if (memRespValid) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == OFF_W'(WORDS - 1)) state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetIn) begin
    if (resetIn) begin
      state_q       <= ST_IDLE;
      beat_q        <= '0;
      memReqValid_q <= 1'b0;
      memReqAddr_q  <= DataBusReset;
      reqAddr_q     <= DataBusReset;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      memReqValid_q <= memReqValid_d;
      memReqAddr_q  <= memReqAddr_d;
      reqAddr_q     <= reqAddr_d;
    end
  end

  assign stateOut    = state_q;
  assign beatOut     = beat_q;
  assign beatWeOut   = (state_q == ST_FILL) && memRespValid;
  assign lastBeatOut = beatWeOut && (beat_q == OFF_W'(WORDS - 1));
  assign reqAddrOut  = reqAddr_q;
  assign memReqValid = memReqValid_q;
  assign memReqAddr  = memReqAddr_q;

endmodule

`default_nettype wire

// File: rtl/inst_cache.sv
// ============================================================================
// inst_cache : direct-mapped instruction cache with burst refill.
//              ICACHE_PERF_EN adds hitCount/missCount outputs.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int DATA_W = DataSize,
  parameter int LINES  = 16,
  parameter int WORDS  = 4
) (
  input  logic              clk,
  input  logic              resetIn,
  input  logic [DATA_W-1:0] addrIn,
  input  logic              reqValid,
  input  logic              flushIn,
  output logic [DATA_W-1:0] instOut,
  output logic              instValid,
  output logic              fetchReady,
  output logic              memReqValid,
  output logic [DATA_W-1:0] memReqAddr,
  input  logic              memReqReady,
  input  logic              memRespValid,
`ifdef ICACHE_PERF_EN
  output logic [31:0]       hitCount,
  output logic [31:0]       missCount,
`endif
  input  logic [DATA_W-1:0] memRespData
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = DATA_W - IDX_W - OFF_W - 2;

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES][WORDS];

  logic [DATA_W-1:0] instOut_q, instOut_d;
  logic              instValid_q, instValid_d;
  logic              flushPend_q, flushPend_d;

  logic [1:0]        state;
  logic [OFF_W-1:0]  beat;
  logic              beatWe, lastBeat;
  logic [DATA_W-1:0] fillAddr;

  logic [OFF_W-1:0]  reqOff, fillOff;
  logic [IDX_W-1:0]  reqIdx, fillIdx;
  logic [TAG_W-1:0]  reqTag, fillTag;
  logic              isIdle, inResp, accept, hit, miss;
  logic              unusedAddrBits;

  assign reqOff  = addrIn[OFF_W+1:2];
  assign reqIdx  = addrIn[OFF_W+IDX_W+1:OFF_W+2];
  assign reqTag  = addrIn[DATA_W-1:OFF_W+IDX_W+2];
  assign fillOff = fillAddr[OFF_W+1:2];
  assign fillIdx = fillAddr[OFF_W+IDX_W+1:OFF_W+2];
  assign fillTag = fillAddr[DATA_W-1:OFF_W+IDX_W+2];
  assign unusedAddrBits = ^{addrIn[1:0], fillAddr[1:0]};

  assign isIdle = (state == ST_IDLE);
  assign inResp = (state == ST_RESP);
  assign accept = isIdle && reqValid;
  // A flush in the same cycle forces a miss even if the line was valid.
  assign hit    = valid_q[reqIdx] && (tag_q[reqIdx] == reqTag) && !flushIn;
  assign miss   = accept && !hit;

  icache_refill_fsm #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS)
  ) u_refill (
    .clk          (clk),
    .resetIn      (resetIn),
    .startIn      (miss),
    .addrIn       (addrIn),
    .memReqReady  (memReqReady),
    .memRespValid (memRespValid),
    .stateOut     (state),
    .beatOut      (beat),
    .beatWeOut    (beatWe),
    .lastBeatOut  (lastBeat),
    .reqAddrOut   (fillAddr),
    .memReqValid  (memReqValid),
    .memReqAddr   (memReqAddr)
  );

  always_comb begin
    valid_d     = valid_q;
    flushPend_d = flushPend_q;
    if ((isIdle && flushIn) || (inResp && (flushPend_q || flushIn))) begin
      valid_d = '0;
    end else if (lastBeat) begin
      valid_d[fillIdx] = 1'b1;
    end
    if (inResp) flushPend_d = 1'b0;
    else if (!isIdle && flushIn) flushPend_d = 1'b1;
  end

  always_comb begin
    instValid_d = 1'b0;
    instOut_d   = instOut_q;
    if (accept && hit) begin
      instValid_d = 1'b1;
      instOut_d   = data_q[reqIdx][reqOff];
    end else if (inResp) begin
      instValid_d = 1'b1;
      instOut_d   = data_q[fillIdx][fillOff];
    end
  end

  always_ff @(posedge clk or posedge resetIn) begin
    if (resetIn) begin
      valid_q     <= '0;
      flushPend_q <= 1'b0;
      instOut_q   <= DataBusReset;
      instValid_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      flushPend_q <= flushPend_d;
      instOut_q   <= instOut_d;
      instValid_q <= instValid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (beatWe) data_q[fillIdx][beat] <= memRespData;
    if (lastBeat) tag_q[fillIdx] <= fillTag;
  end

  assign instOut    = instOut_q;
  assign instValid  = instValid_q;
  assign fetchReady = isIdle;

`ifdef ICACHE_PERF_EN
  logic [31:0] hitCount_q, missCount_q;

  always_ff @(posedge clk or posedge resetIn) begin
    if (resetIn) begin
      hitCount_q  <= '0;
      missCount_q <= '0;
    end else begin
      if (accept && hit) hitCount_q <= hitCount_q + 32'd1;
      if (miss) missCount_q <= missCount_q + 32'd1;
    end
  end

  assign hitCount  = hitCount_q;
  assign missCount = missCount_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_cache.sv
// ============================================================================
// tb_inst_cache : scoreboard bench for inst_cache with an inline memory model
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_inst_cache;

  logic        clk = 1'b0;
  logic        resetIn;
  logic [31:0] addrIn;
  logic        reqValid, flushIn;
  logic [31:0] instOut;
  logic        instValid, fetchReady;
  logic        memReqValid;
  logic [31:0] memReqAddr;
  logic        memReqReady, memRespValid;
  logic [31:0] memRespData;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] sb [$];
  logic [31:0] sb_exp;

  always #5 clk = ~clk;

  inst_cache dut (
    .clk          (clk),
    .resetIn      (resetIn),
    .addrIn       (addrIn),
    .reqValid     (reqValid),
    .flushIn      (flushIn),
    .instOut      (instOut),
    .instValid    (instValid),
    .fetchReady   (fetchReady),
    .memReqValid  (memReqValid),
    .memReqAddr   (memReqAddr),
    .memReqReady  (memReqReady),
    .memRespValid (memRespValid),
    .memRespData  (memRespData)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'h10) return 32'h11 * (32'(a[3:2]) + 32'd1);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Every instruction the cache emits must match the oldest expected word.
  always @(negedge clk) begin
    if (!resetIn && instValid) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_inst", instOut, 32'hxxxx_xxxx);
      end else begin
        sb_exp = sb.pop_front();
        chk("sb_inst", instOut, sb_exp);
      end
    end
  end

  task automatic do_miss(input logic [31:0] a, input int delay,
                         input bit flush_req, input int flush_beat);
    logic [31:0] line;
    line = {a[31:4], 4'h0};
    sb.push_back(mem_word(a));
    addrIn   = a;
    reqValid = 1'b1;
    flushIn  = flush_req;
    tick;
    reqValid = 1'b0;
    flushIn  = 1'b0;
    chk("req_valid", 32'(memReqValid), 32'd1);
    chk("req_addr", memReqAddr, line);
    chk("req_fetch_ready", 32'(fetchReady), 32'd0);
    chk("req_no_inst", 32'(instValid), 32'd0);
    for (int i = 0; i < delay; i++) begin
      tick;
      chk("stall_req_valid", 32'(memReqValid), 32'd1);
      chk("stall_req_addr", memReqAddr, line);
      chk("stall_fetch_ready", 32'(fetchReady), 32'd0);
    end
    memReqReady = 1'b1;
    tick;
    memReqReady = 1'b0;
    chk("req_drop", 32'(memReqValid), 32'd0);
    for (int b = 0; b < 4; b++) begin
      memRespValid = 1'b1;
      memRespData  = mem_word(line + 32'(b) * 32'd4);
      flushIn      = (b == flush_beat);
      tick;
    end
    memRespValid = 1'b0;
    flushIn      = 1'b0;
    chk("fill_no_inst", 32'(instValid), 32'd0);
    chk("fill_fetch_ready", 32'(fetchReady), 32'd0);
    tick;
    chk("resp_valid", 32'(instValid), 32'd1);
    chk("resp_fetch_ready", 32'(fetchReady), 32'd1);
  endtask

  task automatic fetch_hit(input logic [31:0] a);
    sb.push_back(mem_word(a));
    addrIn   = a;
    reqValid = 1'b1;
    tick;
    chk("hit_valid", 32'(instValid), 32'd1);
    chk("hit_no_memreq", 32'(memReqValid), 32'd0);
    chk("hit_fetch_ready", 32'(fetchReady), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetIn      = 1'b1;
    addrIn       = '0;
    reqValid     = 1'b0;
    flushIn      = 1'b0;
    memReqReady  = 1'b0;
    memRespValid = 1'b0;
    memRespData  = '0;
    tick;
    tick;
    chk("rst_inst_valid", 32'(instValid), 32'd0);
    chk("rst_inst_out", instOut, 32'd0);
    chk("rst_mem_req_valid", 32'(memReqValid), 32'd0);
    chk("rst_mem_req_addr", memReqAddr, 32'd0);
    resetIn = 1'b0;
    tick;
    chk("rst_fetch_ready", 32'(fetchReady), 32'd1);

    // Cold miss on line 0, then back-to-back hits on the rest of the line.
    do_miss(32'h0, 0, 1'b0, -1);
    fetch_hit(32'h4);
    fetch_hit(32'h8);
    fetch_hit(32'hC);
    fetch_hit(32'h0);
    reqValid = 1'b0;
    tick;
    chk("idle_no_inst", 32'(instValid), 32'd0);
    chk("idle_hold_inst", instOut, 32'h11);

    // Conflict eviction with a stalled memory, then the old line misses again.
    do_miss(32'h100, 5, 1'b0, -1);
    fetch_hit(32'h108);
    do_miss(32'h0, 1, 1'b0, -1);

    // Flush during FILL still delivers, but the line is gone afterwards.
    do_miss(32'h48, 0, 1'b0, 1);
    do_miss(32'h48, 0, 1'b0, -1);
    fetch_hit(32'h4C);

    // Flush in IDLE with a request: forced miss, and every other line is dropped.
    do_miss(32'h44, 0, 1'b1, -1);
    do_miss(32'h0, 0, 1'b0, -1);
    fetch_hit(32'h40);

    // Reset two beats into a refill; stray beats afterwards are ignored.
    reqValid = 1'b0;
    addrIn   = 32'h200;
    reqValid = 1'b1;
    tick;
    reqValid    = 1'b0;
    memReqReady = 1'b1;
    tick;
    memReqReady = 1'b0;
    for (int b = 0; b < 2; b++) begin
      memRespValid = 1'b1;
      memRespData  = mem_word(32'h200 + 32'(b) * 32'd4);
      tick;
    end
    resetIn = 1'b1;
    #1;
    chk("midrst_mem_req_valid", 32'(memReqValid), 32'd0);
    chk("midrst_inst_valid", 32'(instValid), 32'd0);
    chk("midrst_fetch_ready", 32'(fetchReady), 32'd1);
    tick;
    resetIn = 1'b0;
    tick;
    tick;
    memRespValid = 1'b0;
    chk("stray_inst_valid", 32'(instValid), 32'd0);
    chk("stray_mem_req_valid", 32'(memReqValid), 32'd0);
    chk("stray_fetch_ready", 32'(fetchReady), 32'd1);
    do_miss(32'h200, 0, 1'b0, -1);
    fetch_hit(32'h204);
    do_miss(32'h0, 0, 1'b0, -1);
    reqValid = 1'b0;
    tick;
    tick;

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
